alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/sail_microarchitecture_pkg.sv | 28 ++
 rtl/branch_compare.sv | 33 +++
 rtl/alu.sv | 62 ++++++
 tb/tb_alu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sail_microarchitecture_pkg.sv
// Shared Sail microarchitecture defines: ALU op codes (ALUctl[3:0]) and
// branch-compare codes (ALUctl[6:4]).
package sail_microarchitecture_pkg;

    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_AND   = 4'b0000;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_OR    = 4'b0001;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD   = 4'b0010;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRL   = 4'b0011;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRA   = 4'b0100;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLL   = 4'b0101;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB   = 4'b0110;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLT   = 4'b0111;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_XOR   = 4'b1000;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRW = 4'b1001;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRS = 4'b1010;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRC = 4'b1011;
    localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLTU  = 4'b1100;

    localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_NONE  = 3'b000;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BEQ   = 3'b001;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BNE   = 3'b010;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLT   = 3'b011;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGE   = 3'b100;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLTU  = 3'b101;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGEU  = 3'b110;
    localparam logic [2:0] kSAIL_MICROARCHITECTURE_ALUCTL_6to4_RSVD  = 3'b111;

endpackage

// File: rtl/branch_compare.sv
// Purely combinational branch comparator; looks only at the operands and
// the branch code, never at the ALU op.
module branch_compare
    import sail_microarchitecture_pkg::*;
(
    input  logic [2:0]  br_code,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    always_comb begin
        taken = 1'b0;
        case (br_code)
            kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BEQ:  taken = eq;
            kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BNE:  taken = !eq;
            kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLT:  taken = lt_s;
            kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGE:  taken = !lt_s;
            kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BLTU: taken = lt_u;
            kSAIL_MICROARCHITECTURE_ALUCTL_6to4_BGEU: taken = !lt_u;
            default:                                  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// 32-bit ALU with registered result and branch-taken flag (1-cycle latency).
// Op mux and output registers live here; branch compare is a sub-module.
module alu
    import sail_microarchitecture_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  ALUctl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUOut,
    output logic        Branch_Enable
);

    logic [3:0]  op;
    logic [2:0]  br_code;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        taken;

    assign op      = ALUctl[3:0];
    assign br_code = ALUctl[6:4];
    assign shamt   = B[4:0];

    always_comb begin
        result = 32'd0;
        case (op)
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_AND:   result = A & B;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_OR:    result = A | B;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD:   result = A + B;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRL:   result = A >> shamt;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SRA:   result = $signed(A) >>> shamt;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLL:   result = A << shamt;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB:   result = A - B;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLT:   result = {31'd0, $signed(A) < $signed(B)};
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_XOR:   result = A ^ B;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRW: result = A;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRS: result = A | B;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_CSRRC: result = (~A) & B;
            kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SLTU:  result = {31'd0, A < B};
            default:                                   result = 32'd0;
        endcase
    end

    branch_compare u_branch_compare (
        .br_code (br_code),
        .a       (A),
        .b       (B),
        .taken   (taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUOut        <= 32'd0;
            Branch_Enable <= 1'b0;
        end else begin
            ALUOut        <= result;
            Branch_Enable <= taken;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, boundary cases, random
// stimulus against a behavioural model, back-to-back and async reset.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  ALUctl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUOut;
    logic        Branch_Enable;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        be;
    } vec_t;

    alu dut (
        .clk           (clk),
        .rst           (rst),
        .ALUctl        (ALUctl),
        .A             (A),
        .B             (B),
        .ALUOut        (ALUOut),
        .Branch_Enable (Branch_Enable)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_out(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int          sh;
        int signed   sa;
        int signed   sb;
        longint      q;
        sh = int'(b % 32);
        sa = a;
        sb = b;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd3:  return 32'(64'(a) / (64'd1 << sh));
            4'd4: begin
                // floor division by 2^sh rounds negative values toward -inf
                q = longint'(sa);
                if (q >= 0) q = q / (longint'(1) << sh);
                else        q = -((-q + (longint'(1) << sh) - 1) / (longint'(1) << sh));
                return 32'(q);
            end
            4'd5:  return 32'(64'(a) * (64'd1 << sh));
            4'd6:  return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return a ^ b;
            4'd9:  return a;
            4'd10: return a | b;
            4'd11: return (~a) & b;
            4'd12: return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_be(input logic [2:0] br, input logic [31:0] a,
                                    input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        case (br)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return sa < sb;
            3'd4: return sa >= sb;
            3'd5: return 64'(a) < 64'(b);
            3'd6: return 64'(a) >= 64'(b);
            default: return 1'b0;
        endcase
    endfunction

    // one operation per cycle: inputs change on the falling edge, outputs are
    // sampled 1 time unit after the next rising edge
    task automatic drive(input logic [6:0] ctl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUctl = ctl;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        ALUctl = 7'h29;
        A      = 32'hA5A5_0001;
        B      = 32'h0000_0002;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ALUOut !== 32'd0 || Branch_Enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: ALUOut=%h BE=%b expected 00000000/0", ALUOut, Branch_Enable);
        end
        @(negedge clk);
        rst    = 1'b0;
        ALUctl = 7'h22;
        A      = 32'd5;
        B      = 32'd7;
        @(posedge clk);
        #1;
        checks++;
        if (ALUOut !== 32'd12 || Branch_Enable !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_result: ALUOut=%h BE=%b expected 0000000c/1", ALUOut, Branch_Enable);
        end
    endtask

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{7'h16, 32'h0000_000F, 32'h0000_0055, 32'hFFFF_FFBA, 1'b0});
        v.push_back('{7'h26, 32'h0000_000E, 32'h0000_0055, 32'hFFFF_FFB9, 1'b1});
        v.push_back('{7'h36, 32'd10000,     32'd111,       32'h0000_26A1, 1'b0});
        v.push_back('{7'h46, 32'd10000,     32'd111,       32'h0000_26A1, 1'b1});
        v.push_back('{7'h36, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE, 1'b1});
        v.push_back('{7'h56, 32'd0,         32'd2,         32'hFFFF_FFFE, 1'b1});
        v.push_back('{7'h66, 32'd16,        32'd2,         32'h0000_000E, 1'b1});
        v.push_back('{7'h56, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE, 1'b0});
        v.push_back('{7'h02, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0});
        v.push_back('{7'h06, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0});
        v.push_back('{7'h04, 32'h8000_0000, 32'h0000_0023, 32'hF000_0000, 1'b0});
        v.push_back('{7'h05, 32'd1,         32'd31,        32'h8000_0000, 1'b0});
        v.push_back('{7'h0B, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_0000, 1'b0});
        v.push_back('{7'h70, 32'd3,         32'd3,         32'h0000_0003, 1'b0});
        foreach (v[i]) begin
            drive(v[i].ctl, v[i].a, v[i].b);
            checks++;
            if (ALUOut !== v[i].out || Branch_Enable !== v[i].be) begin
                failures++;
                $display("FAIL directed[%0d] ctl=%h: ALUOut=%h BE=%b expected %h/%b",
                         i, v[i].ctl, ALUOut, Branch_Enable, v[i].out, v[i].be);
            end
        end
    endtask

    task automatic test_boundaries();
        vec_t v[$];
        v.push_back('{7'h04, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0});
        v.push_back('{7'h03, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1'b0});
        v.push_back('{7'h05, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0});
        v.push_back('{7'h04, 32'h8123_4567, 32'hFFFF_FFE0, 32'h8123_4567, 1'b0});
        v.push_back('{7'h07, 32'h8000_0000, 32'd0,         32'h0000_0001, 1'b0});
        v.push_back('{7'h0C, 32'h8000_0000, 32'd0,         32'h0000_0000, 1'b0});
        v.push_back('{7'h0D, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b0});
        v.push_back('{7'h0E, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b0});
        v.push_back('{7'h1F, 32'h0000_0042, 32'h0000_0042, 32'h0000_0000, 1'b1});
        foreach (v[i]) begin
            drive(v[i].ctl, v[i].a, v[i].b);
            checks++;
            if (ALUOut !== v[i].out || Branch_Enable !== v[i].be) begin
                failures++;
                $display("FAIL boundary[%0d] ctl=%h: ALUOut=%h BE=%b expected %h/%b",
                         i, v[i].ctl, ALUOut, Branch_Enable, v[i].out, v[i].be);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  ctl;
        logic [31:0] exp_out;
        logic        exp_be;
        for (int i = 0; i < 400; i++) begin
            ctl = 7'($urandom);
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 32'h8000_0000;
                2: b = 32'($urandom_range(0, 63));
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            exp_out = ref_out(ctl[3:0], a, b);
            exp_be  = ref_be(ctl[6:4], a, b);
            drive(ctl, a, b);
            checks++;
            if (ALUOut !== exp_out || Branch_Enable !== exp_be) begin
                failures++;
                $display("FAIL random[%0d] ctl=%h A=%h B=%h: ALUOut=%h BE=%b expected %h/%b",
                         i, ctl, a, b, ALUOut, Branch_Enable, exp_out, exp_be);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] a;
        // consecutive ADDs of distinct operands: each edge must show the newest sum
        for (int i = 0; i < 16; i++) begin
            a = 32'h1000 * (i + 1);
            exp_q.push_back(a + 32'd3);
            drive(7'h02, a, 32'd3);
            checks++;
            if (ALUOut !== exp_q[0]) begin
                failures++;
                $display("FAIL back_to_back[%0d]: ALUOut=%h expected %h", i, ALUOut, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_async_reset();
        drive(7'h29, 32'h0000_1234, 32'h0000_0001);
        checks++;
        if (ALUOut !== 32'h0000_1234 || Branch_Enable !== 1'b1) begin
            failures++;
            $display("FAIL async_setup: ALUOut=%h BE=%b expected 00001234/1", ALUOut, Branch_Enable);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ALUOut !== 32'd0 || Branch_Enable !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_immediate: ALUOut=%h BE=%b expected 00000000/0", ALUOut, Branch_Enable);
        end
        @(negedge clk);
        ALUctl = 7'h22;
        A      = 32'd40;
        B      = 32'd2;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ALUOut !== 32'd0 || Branch_Enable !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_discard: ALUOut=%h BE=%b expected 00000000/0", ALUOut, Branch_Enable);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ALUOut !== 32'd42 || Branch_Enable !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_resume: ALUOut=%h BE=%b expected 0000002a/1", ALUOut, Branch_Enable);
        end
    endtask

    initial begin
        rst    = 1'b1;
        ALUctl = 7'd0;
        A      = 32'd0;
        B      = 32'd0;
        test_reset();
        test_directed();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
